// File: rtl/bike_bram_port_arbiter_pkg.sv
// Shared types and defaults for BIKE BRAM port sharing: arbiter states,
// read-tag records and the round-robin pick used by the arbiter.
package bike_bram_port_arbiter_pkg;

    localparam int BRAM_ADDR_W  = 10;
    localparam int BRAM_DATA_W  = 32;
    localparam bit BRAM_OUT_REG = 1'b1;

    // An output-registered BRAM adds one cycle on top of the array read.
    localparam int BRAM_RD_LAT   = BRAM_OUT_REG ? 2 : 1;
    localparam int ARB_MAX_BURST = 1 << (BRAM_ADDR_W - 4);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B,
        DRAIN
    } arb_state_t;

    typedef enum logic {
        OWNER_A,
        OWNER_B
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    // On a tie the requester that was not served last wins.
    function automatic arb_state_t arb_pick(input logic req_a, input logic req_b,
                                            input owner_t last_served);
        if (req_a && req_b) return (last_served == OWNER_B) ? OWN_A : OWN_B;
        if (req_a)          return OWN_A;
        if (req_b)          return OWN_B;
        return IDLE;
    endfunction

endpackage

// File: rtl/bike_rd_tag_pipe.sv
// DEPTH-deep {valid, owner} shift register that follows BRAM reads to their
// data cycle; the tail lines up with mem_dout, empty means nothing in flight.
module bike_rd_tag_pipe
    import bike_bram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = BRAM_RD_LAT
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  owner_t  push_owner,
    output rd_tag_t tail,
    output logic    empty
);

    rd_tag_t stage [DEPTH];

    // NOTE: unlike the BRAM array this pipe is reset, so in-flight reads are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{valid: push, owner: push_owner};
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // NOTE: empty gets its default first so the loop cannot infer a latch.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage[i].valid) empty = 1'b0;
        end
    end

    assign tail = stage[DEPTH-1];

endmodule

// File: rtl/bike_bram_port_arbiter.sv
// Two-requester round-robin arbiter for one BIKE BRAM port with burst limit,
// read drain on hand-over and per-requester read-data tagging.
module bike_bram_port_arbiter
    import bike_bram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = BRAM_ADDR_W,
    parameter int DATA_W    = BRAM_DATA_W,
    parameter int RD_LAT    = BRAM_RD_LAT,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    output logic              gnt_a,
    input  logic              ren_a,
    input  logic              wen_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic              rvalid_a,
    input  logic              req_b,
    output logic              gnt_b,
    input  logic              ren_b,
    input  logic              wen_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic              rvalid_b,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    arb_state_t       arb_next;
    owner_t           last_served;
    logic [CNT_W-1:0] burst_cnt;
    logic             sel_a, sel_b;
    logic             acc_a, acc_b;
    logic             cnt_full;
    logic             leave_a, leave_b;
    logic             tag_empty;
    rd_tag_t          tag_tail;

    assign sel_a = gnt_a && req_a;
    assign sel_b = gnt_b && req_b;
    assign acc_a = sel_a && (ren_a || wen_a);
    assign acc_b = sel_b && (ren_b || wen_b);

    assign mem_ren  = (sel_a && ren_a) || (sel_b && ren_b);
    assign mem_wen  = (sel_a && wen_a) || (sel_b && wen_b);
    assign mem_addr = sel_a ? addr_a : (sel_b ? addr_b : '0);
    assign mem_din  = sel_a ? din_a  : (sel_b ? din_b  : '0);

    assign cnt_full = (burst_cnt == CNT_W'(MAX_BURST));
    assign leave_a  = !req_a || (cnt_full && req_b);
    assign leave_b  = !req_b || (cnt_full && req_a);
    assign arb_next = arb_pick(req_a, req_b, last_served);

    bike_rd_tag_pipe #(
        .DEPTH(RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_ren),
        .push_owner(sel_b ? OWNER_B : OWNER_A),
        .tail      (tag_tail),
        .empty     (tag_empty)
    );

    assign rdata    = mem_dout;
    assign rvalid_a = tag_tail.valid && (tag_tail.owner == OWNER_A);
    assign rvalid_b = tag_tail.valid && (tag_tail.owner == OWNER_B);
    assign busy     = (state != IDLE);

    // NOTE: grants are registered from the next state, never decoded from req.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            last_served <= OWNER_B;
            burst_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= arb_next;
                    gnt_a <= (arb_next == OWN_A);
                    gnt_b <= (arb_next == OWN_B);
                end
                OWN_A: begin
                    if (leave_a) begin
                        state       <= DRAIN;
                        gnt_a       <= 1'b0;
                        last_served <= OWNER_A;
                        burst_cnt   <= '0;
                    end else if (acc_a && !cnt_full) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                OWN_B: begin
                    if (leave_b) begin
                        state       <= DRAIN;
                        gnt_b       <= 1'b0;
                        last_served <= OWNER_B;
                        burst_cnt   <= '0;
                    end else if (acc_b && !cnt_full) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Hand over only once every issued read has returned.
                    if (tag_empty) begin
                        state <= arb_next;
                        gnt_a <= (arb_next == OWN_A);
                        gnt_b <= (arb_next == OWN_B);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bike_bram_port_arbiter.sv
// Directed bench for bike_bram_port_arbiter: cycle table for the handshake
// and tagging cases, hand sequences for burst limit and idle masking.
module tb_bike_bram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_a, gnt_a, ren_a, wen_a, rvalid_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] din_a;
    logic              req_b, gnt_b, ren_b, wen_b, rvalid_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] din_b;
    logic              mem_ren, mem_wen, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din, mem_dout, rdata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    bike_bram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .gnt_a(gnt_a), .ren_a(ren_a), .wen_a(wen_a),
        .addr_a(addr_a), .din_a(din_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .gnt_b(gnt_b), .ren_b(ren_b), .wen_b(wen_b),
        .addr_b(addr_b), .din_b(din_b), .rvalid_b(rvalid_b),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .rdata(rdata), .busy(busy)
    );

    // Two-stage BRAM; contents reload to D000_0000|addr while reset is held.
    logic [DATA_W-1:0] mem [0:1023];
    logic [DATA_W-1:0] bram_s1, bram_s2;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hD000_0000 | 32'(i);
            bram_s1 <= '0;
            bram_s2 <= '0;
        end else begin
            if (mem_wen) mem[mem_addr] <= mem_din;
            bram_s1 <= mem[mem_addr];
            bram_s2 <= bram_s1;
        end
    end
    assign mem_dout = bram_s2;

    typedef struct {
        logic              rst, ra, rena, wena;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] da;
        logic              rb, renb, wenb;
        logic [ADDR_W-1:0] ab;
        logic [DATA_W-1:0] db;
        logic              chk, ga, gb, va, vb, bsy, mren, mwen;
        logic [ADDR_W-1:0] maddr;
        logic [DATA_W-1:0] mdin;
        logic              crd;
        logic [DATA_W-1:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rst, ra, rena, wena, aa, input logic [31:0] da,
                                input int rb, renb, wenb, ab, input logic [31:0] db,
                                input int chk, ga, gb, va, vb, bsy, mren, mwen, maddr,
                                input logic [31:0] mdin, input int crd,
                                input logic [31:0] rd);
        vec_t r;
        r.rst = 1'(rst);  r.ra = 1'(ra);    r.rena = 1'(rena); r.wena = 1'(wena);
        r.aa  = 10'(aa);  r.da = da;
        r.rb  = 1'(rb);   r.renb = 1'(renb); r.wenb = 1'(wenb);
        r.ab  = 10'(ab);  r.db = db;
        r.chk = 1'(chk);  r.ga = 1'(ga);    r.gb = 1'(gb);
        r.va  = 1'(va);   r.vb = 1'(vb);    r.bsy = 1'(bsy);
        r.mren = 1'(mren); r.mwen = 1'(mwen); r.maddr = 10'(maddr);
        r.mdin = mdin;    r.crd = 1'(crd);  r.rd = rd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        req_a = 0; ren_a = 0; wen_a = 0; addr_a = '0; din_a = '0;
        req_b = 0; ren_b = 0; wen_b = 0; addr_b = '0; din_b = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic fill_table();
        // rst,ra,rena,wena,aa,da, rb,renb,wenb,ab,db, chk,ga,gb,va,vb,bsy,mren,mwen,maddr,mdin,crd,rd
        // single-requester read/write, latency and masking
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,5,0, 0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,5,0, 0,0,0,0,0, 1,1,0,0,0,1,1,0,5,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,1,0,1,0,1,0,0,0,0, 1,'hD000_0005));
        vecs.push_back(mk(0,1,0,1,7,'h1111_2222, 0,0,0,0,0, 1,1,0,0,0,1,0,1,7,'h1111_2222, 0,0));
        vecs.push_back(mk(0,1,1,1,9,'h3333_4444, 0,0,0,0,0, 1,1,0,0,0,1,1,1,9,'h3333_4444, 0,0));
        vecs.push_back(mk(0,1,1,0,7,0, 0,0,0,0,0, 1,1,0,0,0,1,1,0,7,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,1,0,1,0,1,0,0,0,0, 1,'hD000_0009));
        vecs.push_back(mk(0,0,1,0,9,0, 0,0,0,0,0, 1,1,0,1,0,1,0,0,0,0, 1,'h1111_2222));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,1,3,'h55, 1,0,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,1,3,'h55, 1,0,0,0,0,0,0,0,0,0, 0,0));
        // simultaneous requests, round-robin ties, B read tagging
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,1,20,'hBBBB_0014, 1,0,1,0,0,1,0,1,20,'hBBBB_0014, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,1,0,20,0, 1,0,1,0,0,1,1,0,20,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0, 1,0,1,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,0,1,0,1,1,0,0,0,0, 1,'hBBBB_0014));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,0,1,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,0,1,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
        // reads in the last two owned cycles delay the hand-over to B
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,30,0, 1,0,0,0,0, 1,1,0,0,0,1,1,0,30,0, 0,0));
        vecs.push_back(mk(0,1,1,0,31,0, 1,0,0,0,0, 1,1,0,0,0,1,1,0,31,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,1,0,1,0,1,0,0,0,0, 1,'hD000_001E));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,0,0,1,0,1,0,0,0,0, 1,'hD000_001F));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 1,0,1,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,0,1,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 0,0));
        // reset one cycle after an accepted read drops it
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,5,0, 0,0,0,0,0, 1,1,0,0,0,1,1,0,5,0, 0,0));
        vecs.push_back(mk(1,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,5,0, 0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,1,0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0));
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            req_a = vecs[i].ra; ren_a = vecs[i].rena; wen_a = vecs[i].wena;
            addr_a = vecs[i].aa; din_a = vecs[i].da;
            req_b = vecs[i].rb; ren_b = vecs[i].renb; wen_b = vecs[i].wenb;
            addr_b = vecs[i].ab; din_b = vecs[i].db;
            settle();
            if (vecs[i].chk) begin
                check($sformatf("v%0d.gnt_a", i),    32'(gnt_a),    32'(vecs[i].ga));
                check($sformatf("v%0d.gnt_b", i),    32'(gnt_b),    32'(vecs[i].gb));
                check($sformatf("v%0d.rvalid_a", i), 32'(rvalid_a), 32'(vecs[i].va));
                check($sformatf("v%0d.rvalid_b", i), 32'(rvalid_b), 32'(vecs[i].vb));
                check($sformatf("v%0d.busy", i),     32'(busy),     32'(vecs[i].bsy));
                check($sformatf("v%0d.mem_ren", i),  32'(mem_ren),  32'(vecs[i].mren));
                check($sformatf("v%0d.mem_wen", i),  32'(mem_wen),  32'(vecs[i].mwen));
                check($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
                check($sformatf("v%0d.mem_din", i),  mem_din,       vecs[i].mdin);
                if (vecs[i].crd) check($sformatf("v%0d.rdata", i), rdata, vecs[i].rd);
            end
            tick();
        end
        reset = 0;
    endtask

    // Writes a burst of n_wr accepted writes from A and returns the count
    // of writes seen on the BRAM port and whether gnt_a ever dropped.
    task automatic a_write_burst(input int n_wr, output int wr_seen, output int gnt_lost);
        wr_seen  = 0;
        gnt_lost = 0;
        for (int i = 0; i < n_wr; i++) begin
            wen_a = 1; addr_a = 10'(i); din_a = 32'hA500_0000 | 32'(i);
            settle();
            if (mem_wen) wr_seen++;
            if (!gnt_a) gnt_lost = 1;
            tick();
        end
        wen_a = 0;
    endtask

    initial begin
        int wr_seen, gnt_lost, waited;
        reset = 1;
        drive_idle();
        fill_table();
        run_table();

        // Burst limit with B waiting: 64 writes, then forced hand-over.
        do_reset();
        req_a = 1; req_b = 1;
        settle(); tick();
        a_write_burst(64, wr_seen, gnt_lost);
        check("burst.writes", 32'(wr_seen), 32'd64);
        check("burst.steady_gnt", 32'(gnt_lost), 32'd0);
        settle();
        check("burst.gnt_a_last", 32'(gnt_a), 32'd1);
        tick(); settle();
        check("burst.gnt_a_drop", 32'(gnt_a), 32'd0);
        check("burst.busy_drain", 32'(busy), 32'd1);
        waited = 0;
        while (!gnt_b && waited < RD_LAT + 1) begin
            tick(); settle();
            waited++;
        end
        check("burst.gnt_b", 32'(gnt_b), 32'd1);
        check("burst.gap", 32'(waited), 32'd1);
        tick();
        req_b = 0;
        settle();
        check("burst.gnt_b_hold", 32'(gnt_b), 32'd1);
        tick(); settle();
        check("burst.regrant_gap", 32'(gnt_a), 32'd0);
        tick(); settle();
        check("burst.regrant_a", 32'(gnt_a), 32'd1);

        // No waiter: A keeps the port past the limit until B shows up.
        do_reset();
        req_a = 1;
        settle(); tick();
        a_write_burst(70, wr_seen, gnt_lost);
        check("nopre.writes", 32'(wr_seen), 32'd70);
        check("nopre.steady_gnt", 32'(gnt_lost), 32'd0);
        req_b = 1;
        settle();
        check("nopre.gnt_a_keep", 32'(gnt_a), 32'd1);
        tick(); settle();
        check("nopre.late_preempt", 32'(gnt_a), 32'd0);
        tick(); settle();
        check("nopre.gnt_b", 32'(gnt_b), 32'd1);

        // Idle port: enables and addresses toggling without req stay masked.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            ren_a = 1; wen_a = 1; addr_a = 10'(c + 1); din_a = 32'(c + 7);
            ren_b = 1; wen_b = 1; addr_b = 10'(c + 100); din_b = 32'(c + 9);
            settle();
            check($sformatf("idle%0d.mem_ren", c),  32'(mem_ren),  32'd0);
            check($sformatf("idle%0d.mem_wen", c),  32'(mem_wen),  32'd0);
            check($sformatf("idle%0d.mem_addr", c), 32'(mem_addr), 32'd0);
            check($sformatf("idle%0d.gnt", c),      32'({gnt_a, gnt_b}), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/bike_bram_port_arbiter.md
Name: bike_bram_port_arbiter

Overview:
- Shares one port of the BIKE generic BRAM between two requesters, A and B. A is typically the sampler and B a compute unit such as the multiplier or decoder.
- Uses a registered request/grant handshake with round-robin fairness and a burst limit so neither requester can starve the other.
- Drains in-flight reads before handing the port to the other requester.
- Tags read data back to the requester that issued the read.

Parameters:
- ADDR_W, 10, BRAM word address width.
- DATA_W, 32, BRAM data width.
- RD_LAT, 2, BRAM read latency in cycles (≥1).
- MAX_BURST, 64, accepted accesses before forced hand-over while the other requester waits (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_a  in  1  A requests port ownership; held for the whole transaction
- gnt_a  out  1  A owns the port (registered)
- ren_a  in  1  A read enable
- wen_a  in  1  A write enable
- addr_a  in  ADDR_W  A address
- din_a  in  DATA_W  A write data
- rvalid_a  out  1  rdata belongs to A this cycle
- req_b, gnt_b, ren_b, wen_b, addr_b, din_b, rvalid_b  as for A
- mem_ren  out  1  to BRAM
- mem_wen  out  1  to BRAM
- mem_addr  out  ADDR_W  to BRAM
- mem_din  out  DATA_W  to BRAM
- mem_dout  in  DATA_W  from BRAM
- rdata  out  DATA_W  mem_dout passed through to both requesters
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, OWN_A, OWN_B, DRAIN.
- Reset (synchronous, active-high):
  - state=IDLE; gnt_a=gnt_b=0; rvalid_*=0; burst counter=0; last_served=B, so A wins the first tie.
  - Read tag pipeline is cleared. Outstanding reads are dropped and never produce an rvalid.
- IDLE:
  - Only req_a → OWN_A next cycle. Only req_b → OWN_B.
  - Both → grant the requester that is not last_served.
  - gnt is registered: req at cycle t gives gnt at t+1.
- OWN_X:
  - gnt_X=1.
  - An access is accepted only when gnt_X && req_X && (ren_X || wen_X).
  - mem_* = X's signals, masked by gnt_X && req_X. With no owner, mem_ren=mem_wen=0 and mem_addr/mem_din=0.
  - ren and wen may both be high; both are forwarded unchanged.
  - Each accepted access increments the burst counter; the counter saturates at MAX_BURST.
- Leave OWN_X when either:
  - req_X=0, or
  - counter==MAX_BURST and the other requester's req=1.
  - On leaving: gnt_X=0 from the next cycle, last_served=X, counter cleared, next state DRAIN.
  - If counter==MAX_BURST but the other req=0, stay in OWN_X.
- DRAIN:
  - No grant is active.
  - Wait until the read tag pipeline is empty, at most RD_LAT cycles.
  - Then apply the IDLE arbitration in the same cycle. Minimum hand-over gap: gnt_X falls at t, gnt_Y rises at t+1 if the pipeline is already empty.
- Read tagging:
  - Shift register of depth RD_LAT holding {valid, owner}.
  - Accepted ren at cycle t → rvalid_X=1 at cycle t+RD_LAT, with rdata=mem_dout in that cycle.
  - rvalid_a and rvalid_b are never both high.
- Preemption: a preempted requester keeps req high and is re-granted after the other requester releases the port or is itself preempted.
- Reset mid-burst: gnt drops in the cycle after reset is sampled, and no pending rvalid appears.

Decomposition:
- BIKE_PACKAGE additions:
  - typedef arb_state_t enum {IDLE, OWN_A, OWN_B, DRAIN}.
  - Constants BRAM_RD_LAT and ARB_MAX_BURST. Their defaults are derived from the existing BRAM configuration.
- One sub-module: bike_rd_tag_pipe. It is the RD_LAT-deep {valid, owner} shift register with an empty flag, and is reused by other BRAM clients.

Test Plan:
- Reset, then req_a=1 at cycle 0 → gnt_a=1 at cycle 1. ren_a, addr_a=5 at cycle 2 → rvalid_a=1 at cycle 4 (RD_LAT=2) with rdata=mem[5].
- req_a=req_b=1 simultaneously after reset → A granted first. A drops req → gnt_a=0, DRAIN, gnt_b=1. The next tie goes to A.
- A holds req and issues 64 writes while req_b=1 → gnt_a drops after the 64th accepted write, and gnt_b rises within RD_LAT+1 cycles.
  - Repeat with req_b=0 → A keeps the grant past 64 writes.
- A issues reads at the last two cycles of ownership, then releases → gnt_b is delayed until both rvalid_a pulses are seen. rvalid_b is never set for A's data.
- reset asserted one cycle after an accepted ren_a → no rvalid_a, gnt_a=0 and busy=0 the next cycle, and mem_ren=0.
- Idle port: no req for 10 cycles → mem_ren=mem_wen=0, mem_addr=0, gnt_a=gnt_b=0.
